// File: rtl/wta_label_ctrl_pkg.sv
// Shared types and defaults for the winner-take-all label controller.
// Holds the FSM state encoding, the parameter defaults and the counter width.
package wta_label_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HOLD    = 2'd1,
      ST_REFRACT = 2'd2
   } state_t;

   localparam int DEF_WIDTH   = 19;
   localparam int DEF_WINDOW  = 16;
   localparam int DEF_REFRACT = 8;
   localparam int CNT_W       = 8;

endpackage

// File: rtl/wta_label_ctrl_onehot5_to_bin.sv
// Combinational one-hot [5:1] to binary 1..5 converter.
// Flags an all-zero input and any input with more than one bit set.
module onehot5_to_bin (
   input  logic [5:1] onehot,
   output logic [2:0] bin,
   output logic       is_zero,
   output logic       is_multi
);

   always_comb begin
      bin      = 3'd0;
      is_zero  = 1'b0;
      is_multi = 1'b0;
      case (onehot)
         5'b00000: is_zero  = 1'b1;
         5'b00001: bin      = 3'd1;
         5'b00010: bin      = 3'd2;
         5'b00100: bin      = 3'd3;
         5'b01000: bin      = 3'd4;
         5'b10000: bin      = 3'd5;
         default:  is_multi = 1'b1;
      endcase
   end

endmodule

// File: rtl/wta_label_ctrl.sv
// Winner-take-all label controller: accepts a comparator winner, waits for a
// supervisor label within a window, then scores it and sits out a refractory period.
module wta_label_ctrl
   import wta_label_ctrl_pkg::*;
#(
   parameter int p_width   = DEF_WIDTH,
   parameter int p_window  = DEF_WINDOW,
   parameter int p_refract = DEF_REFRACT
) (
   input  logic               w_nclk,
   input  logic               i_rst_n,
   input  logic [5:1]         i_index,
   input  logic [p_width-1:0] i_result,
   input  logic               i_label_valid,
   input  logic [5:1]         i_label,
   output logic               o_event,
   output logic [2:0]         o_winner,
   output logic [p_width-1:0] o_potential,
   output logic               o_reward,
   output logic               o_punish,
   output logic               o_miss,
   output logic               o_err,
   output logic               o_busy,
   output logic [CNT_W-1:0]   o_reward_cnt
);

   localparam logic [CNT_W-1:0] WINDOW_LOAD  = CNT_W'(p_window - 1);
   localparam logic [CNT_W-1:0] REFRACT_LOAD = CNT_W'(p_refract - 1);
   localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [5:1]         win_onehot, win_onehot_n;
   logic [2:0]         winner_n;
   logic [p_width-1:0] potential_n;
   logic               event_n, reward_n, punish_n, miss_n, err_n, busy_n;
   logic [CNT_W-1:0]   reward_cnt_n;

   logic [2:0]         idx_bin;
   logic               idx_zero;
   logic               idx_multi;

   onehot5_to_bin u_idx_dec (
      .onehot   (i_index),
      .bin      (idx_bin),
      .is_zero  (idx_zero),
      .is_multi (idx_multi)
   );

   // State, counter, latched winner and every output are registered together.
   always_ff @(posedge w_nclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         win_onehot   <= '0;
         o_winner     <= '0;
         o_potential  <= '0;
         o_event      <= 1'b0;
         o_reward     <= 1'b0;
         o_punish     <= 1'b0;
         o_miss       <= 1'b0;
         o_err        <= 1'b0;
         o_busy       <= 1'b0;
         o_reward_cnt <= '0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         win_onehot   <= win_onehot_n;
         o_winner     <= winner_n;
         o_potential  <= potential_n;
         o_event      <= event_n;
         o_reward     <= reward_n;
         o_punish     <= punish_n;
         o_miss       <= miss_n;
         o_err        <= err_n;
         o_busy       <= busy_n;
         o_reward_cnt <= reward_cnt_n;
      end
   end

   // Next-state and next-output logic; pulses default low every cycle.
   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      win_onehot_n = win_onehot;
      winner_n     = o_winner;
      potential_n  = o_potential;
      event_n      = 1'b0;
      reward_n     = 1'b0;
      punish_n     = 1'b0;
      miss_n       = 1'b0;
      err_n        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (idx_multi) begin
               err_n = 1'b1;
            end else if (!idx_zero) begin
               event_n      = 1'b1;
               win_onehot_n = i_index;
               winner_n     = idx_bin;
               potential_n  = i_result;
               if (i_label_valid) begin
                  reward_n = (i_label == i_index);
                  punish_n = (i_label != i_index);
                  cnt_n    = REFRACT_LOAD;
                  state_n  = ST_REFRACT;
               end else begin
                  cnt_n   = WINDOW_LOAD;
                  state_n = ST_HOLD;
               end
            end else if (i_label_valid) begin
               miss_n = 1'b1;
            end
         end
         ST_HOLD: begin
            if (i_label_valid) begin
               reward_n = (i_label == win_onehot);
               punish_n = (i_label != win_onehot);
               cnt_n    = REFRACT_LOAD;
               state_n  = ST_REFRACT;
            end else if (cnt == '0) begin
               miss_n  = 1'b1;
               cnt_n   = REFRACT_LOAD;
               state_n = ST_REFRACT;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         ST_REFRACT: begin
            if (cnt == '0) begin
               state_n = ST_IDLE;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
         end
      endcase
      busy_n       = (state_n != ST_IDLE);
      reward_cnt_n = o_reward_cnt;
      if (reward_n && (o_reward_cnt != CNT_MAX)) begin
         reward_cnt_n = o_reward_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_wta_label_ctrl.sv
// Self-checking bench for wta_label_ctrl: a table of single-edge IDLE vectors
// followed by hand-written multi-cycle sequences.
module tb_wta_label_ctrl;

   logic        w_nclk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic [5:1]  i_index = '0;
   logic [18:0] i_result = '0;
   logic        i_label_valid = 1'b0;
   logic [5:1]  i_label = '0;
   logic        o_event;
   logic [2:0]  o_winner;
   logic [18:0] o_potential;
   logic        o_reward, o_punish, o_miss, o_err, o_busy;
   logic [7:0]  o_reward_cnt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [5:1]  index;
      logic [18:0] result;
      logic        label_valid;
      logic [5:1]  label;
      logic        ev;
      logic [2:0]  winner;
      logic [18:0] pot;
      logic        reward;
      logic        punish;
      logic        miss;
      logic        err;
      logic        busy;
      logic [7:0]  cnt;
   } vec_t;

   vec_t vecs [8];

   wta_label_ctrl dut (
      .w_nclk        (w_nclk),
      .i_rst_n       (i_rst_n),
      .i_index       (i_index),
      .i_result      (i_result),
      .i_label_valid (i_label_valid),
      .i_label       (i_label),
      .o_event       (o_event),
      .o_winner      (o_winner),
      .o_potential   (o_potential),
      .o_reward      (o_reward),
      .o_punish      (o_punish),
      .o_miss        (o_miss),
      .o_err         (o_err),
      .o_busy        (o_busy),
      .o_reward_cnt  (o_reward_cnt)
   );

   always #5 w_nclk = ~w_nclk;

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge w_nclk);
      #1;
   endtask

   task automatic drive(input logic [5:1] idx, input logic [18:0] res,
                        input logic lv, input logic [5:1] lab);
      i_index       = idx;
      i_result      = res;
      i_label_valid = lv;
      i_label       = lab;
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      drive('0, '0, 1'b0, '0);
      repeat (2) @(posedge w_nclk);
      #2;
      i_rst_n = 1'b1;
   endtask

   task automatic check_pulses_zero(input string name);
      check_val(name, {27'd0, o_event, o_reward, o_punish, o_miss, o_err}, 32'd0);
   endtask

   task automatic check_output(input vec_t v, input int n);
      check_val($sformatf("v%0d_event", n),  o_event,      v.ev);
      check_val($sformatf("v%0d_winner", n), o_winner,     v.winner);
      check_val($sformatf("v%0d_pot", n),    o_potential,  v.pot);
      check_val($sformatf("v%0d_reward", n), o_reward,     v.reward);
      check_val($sformatf("v%0d_punish", n), o_punish,     v.punish);
      check_val($sformatf("v%0d_miss", n),   o_miss,       v.miss);
      check_val($sformatf("v%0d_err", n),    o_err,        v.err);
      check_val($sformatf("v%0d_busy", n),   o_busy,       v.busy);
      check_val($sformatf("v%0d_cnt", n),    o_reward_cnt, v.cnt);
   endtask

   task automatic apply_stimulus(input vec_t v);
      do_reset();
      drive(v.index, v.result, v.label_valid, v.label);
      step();
      drive('0, '0, 1'b0, '0);
   endtask

   initial begin
      int exp_cnt;
      int pulse_seen;

      //           index     result  lv  label     ev win pot     rw pu mi er bz cnt
      vecs[0] = '{5'b00100, 19'd100, 0, 5'b00000, 1, 3, 19'd100, 0, 0, 0, 0, 1, 0};
      vecs[1] = '{5'b00001, 19'd7,   1, 5'b10000, 1, 1, 19'd7,   0, 1, 0, 0, 1, 0};
      vecs[2] = '{5'b00010, 19'd55,  1, 5'b00010, 1, 2, 19'd55,  1, 0, 0, 0, 1, 1};
      vecs[3] = '{5'b00110, 19'd9,   0, 5'b00000, 0, 0, 19'd0,   0, 0, 0, 1, 0, 0};
      vecs[4] = '{5'b00000, 19'd3,   1, 5'b00001, 0, 0, 19'd0,   0, 0, 1, 0, 0, 0};
      vecs[5] = '{5'b10000, 19'd524287, 0, 5'b00000, 1, 5, 19'd524287, 0, 0, 0, 0, 1, 0};
      vecs[6] = '{5'b11111, 19'd1,   1, 5'b11111, 0, 0, 19'd0,   0, 0, 0, 1, 0, 0};
      vecs[7] = '{5'b00000, 19'd77,  0, 5'b00000, 0, 0, 19'd0,   0, 0, 0, 0, 0, 0};

      do_reset();
      #1;
      check_val("reset_winner", o_winner, 0);
      check_val("reset_busy", o_busy, 0);
      check_val("reset_cnt", o_reward_cnt, 0);

      for (int i = 0; i < 8; i++) begin
         apply_stimulus(vecs[i]);
         check_output(vecs[i], i);
      end

      // Winner, label three edges later, then eight refractory cycles.
      do_reset();
      drive(5'b00100, 19'd100, 1'b0, '0);
      step();
      check_val("a_event", o_event, 1);
      check_val("a_winner", o_winner, 3);
      check_val("a_pot", o_potential, 100);
      drive('0, '0, 1'b0, '0);
      step();
      check_pulses_zero("a_hold1");
      step();
      check_pulses_zero("a_hold2");
      drive('0, '0, 1'b1, 5'b00100);
      step();
      check_val("a_reward", o_reward, 1);
      check_val("a_punish", o_punish, 0);
      check_val("a_cnt", o_reward_cnt, 1);
      drive('0, '0, 1'b0, '0);
      repeat (7) step();
      check_val("a_busy_refract7", o_busy, 1);
      step();
      check_val("a_busy_refract8", o_busy, 0);
      check_val("a_winner_kept", o_winner, 3);

      // No label: miss exactly 16 edges after the event; new winners ignored.
      do_reset();
      drive(5'b01000, 19'd42, 1'b0, '0);
      step();
      check_val("b_event", o_event, 1);
      pulse_seen = 0;
      for (int k = 1; k <= 15; k++) begin
         if (k == 5) drive(5'b00001, 19'd11, 1'b0, '0);
         else drive('0, '0, 1'b0, '0);
         step();
         if ({o_event, o_reward, o_punish, o_miss, o_err} != 5'b0) pulse_seen++;
      end
      check_val("b_hold_quiet", pulse_seen, 0);
      check_val("b_winner_hold", o_winner, 4);
      step();
      check_val("b_miss16", o_miss, 1);
      check_val("b_winner_miss", o_winner, 4);
      check_val("b_pot_miss", o_potential, 42);
      drive(5'b00010, 19'd5, 1'b1, 5'b00010);
      pulse_seen = 0;
      for (int k = 1; k <= 8; k++) begin
         step();
         if ({o_event, o_reward, o_punish, o_miss, o_err} != 5'b0) pulse_seen++;
      end
      drive('0, '0, 1'b0, '0);
      check_val("b_refract_quiet", pulse_seen, 0);
      check_val("b_busy_end", o_busy, 0);
      check_val("b_winner_end", o_winner, 4);
      check_val("b_cnt_end", o_reward_cnt, 0);

      // Reward saturation over 300 same-cycle rewards.
      do_reset();
      exp_cnt = 0;
      for (int n = 1; n <= 300; n++) begin
         drive(5'b00001, 19'd1, 1'b1, 5'b00001);
         step();
         drive('0, '0, 1'b0, '0);
         if (exp_cnt < 255) exp_cnt++;
         if (n == 1 || n == 254 || n == 255 || n == 256 || n == 300)
            check_val($sformatf("c_cnt_%0d", n), o_reward_cnt, exp_cnt);
         repeat (8) step();
      end
      check_val("c_busy", o_busy, 0);

      // Asynchronous reset mid-HOLD, then a fresh winner.
      do_reset();
      drive(5'b00100, 19'd9, 1'b0, '0);
      step();
      drive('0, '0, 1'b0, '0);
      repeat (3) step();
      check_val("d_busy_pre", o_busy, 1);
      i_rst_n = 1'b0;
      #1;
      check_val("d_rst_winner", o_winner, 0);
      check_val("d_rst_pot", o_potential, 0);
      check_val("d_rst_busy", o_busy, 0);
      check_val("d_rst_cnt", o_reward_cnt, 0);
      @(posedge w_nclk);
      #2;
      i_rst_n = 1'b1;
      drive(5'b00010, 19'd5, 1'b0, '0);
      step();
      drive('0, '0, 1'b0, '0);
      check_val("d_event", o_event, 1);
      check_val("d_winner", o_winner, 2);
      check_val("d_pot", o_potential, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wta_label_ctrl.md
WTA_LABEL_CTRL -- requirements
Module: wta_label_ctrl

Interface
REQ-001 Parameter p_width, default 19, width of the winner potential.
REQ-002 Parameter p_window, default 16, number of HOLD cycles allowed for a label (legal range 1..255).
REQ-003 Parameter p_refract, default 8, number of REFRACT cycles (legal range 1..255).
REQ-004 w_nclk  input  1  block clock; all state changes on its rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_index  input  5 [5:1]  winner index from the 5-input comparator; zero means no winner.
REQ-007 i_result  input  p_width  winning potential, aligned with i_index.
REQ-008 i_label_valid  input  1  supervisor label strobe, one cycle per label.
REQ-009 i_label  input  5 [5:1]  one-hot target neuron, meaningful when i_label_valid=1.
REQ-010 o_event  output  1  one-cycle pulse: winner accepted.
REQ-011 o_winner  output  3  binary winner number 1..5; 0 means none.
REQ-012 o_potential  output  p_width  latched potential of the accepted winner.
REQ-013 o_reward / o_punish / o_miss / o_err  output  1 each  one-cycle pulses.
REQ-014 o_busy  output  1  high whenever state is not IDLE.
REQ-015 o_reward_cnt  output  8  saturating count of reward pulses.

Function
REQ-016 States: IDLE, HOLD, REFRACT; all outputs are registered; pulse outputs default low every cycle.
REQ-017 IDLE, i_index exactly one-hot: latch o_winner and o_potential, pulse o_event on the same edge, load the window counter with p_window-1, and go to HOLD.
REQ-018 IDLE, i_index non-zero but not one-hot: pulse o_err, latch nothing, and stay in IDLE.
REQ-019 IDLE, i_label_valid=1 with i_index=0: pulse o_miss and stay in IDLE.
REQ-020 IDLE, one-hot winner and i_label_valid in the same cycle: on one edge, pulse o_event together with o_reward if i_label equals i_index, else o_punish; load the refract counter with p_refract-1 and go to REFRACT.
REQ-021 HOLD, i_label_valid=1: pulse o_reward if i_label equals the latched one-hot winner, else o_punish; load the refract counter and go to REFRACT.
REQ-022 HOLD without a label: decrement the window counter; when the counter is 0 and no label arrives, pulse o_miss and go to REFRACT, so HOLD lasts exactly p_window cycles.
REQ-023 HOLD: i_index is ignored; a new winner does not replace the latched one.
REQ-024 REFRACT: i_index and i_label_valid are ignored, with no pulses; decrement the counter and go to IDLE on the edge where the counter is 0, so REFRACT lasts exactly p_refract cycles.
REQ-025 o_winner and o_potential hold their values until the next accepted winner.
REQ-026 o_reward_cnt increments on each reward and saturates at 255; it is never wrapped.
REQ-027 Latency: an input sampled at edge n produces its response pulse in the cycle after edge n.

Reset
REQ-028 Asserting i_rst_n low at any time, including mid-HOLD or mid-REFRACT, forces IDLE and clears all outputs, counters and latched values to 0 immediately.
REQ-029 After reset release, the first rising edge of w_nclk evaluates inputs as in IDLE.

Structure
REQ-030 The shared package holds the state enumeration, the default values of p_window, p_refract and p_width, and the counter width constant (8).
REQ-031 Sub-module onehot5_to_bin: combinational; converts [5:1] one-hot to binary 1..5 and flags zero or multi-hot; instantiated once, for i_index.

Verification
REQ-032 i_index=5'b00100, i_result=100, then label 5'b00100 three cycles later -> o_event, o_winner=3, o_potential=100, then o_reward; o_reward_cnt=1; o_busy low after 8 REFRACT cycles.
REQ-033 i_index=5'b00001, label 5'b10000 in the same cycle -> o_event and o_punish on the same edge; state goes to REFRACT.
REQ-034 i_index=5'b01000 with no label -> o_miss exactly 16 cycles after o_event; o_winner stays 4.
REQ-035 i_index=5'b00110 -> o_err pulse only, o_busy stays 0; i_index=0 with label -> o_miss only.
REQ-036 Rewards repeated 300 times -> o_reward_cnt=255; new winners during HOLD or REFRACT produce no pulses.
REQ-037 Reset asserted mid-HOLD -> all outputs are 0 asynchronously; after release, i_index=5'b00010 -> o_event, o_winner=2.
